// File: rtl/rgb_pwm_encoder.sv
// Three-channel PWM encoder with a double-buffered duty triple and global brightness scaling.
// New duties are latched into a pending buffer and promoted to the active set only at a period boundary.
module rgb_pwm_encoder #(
    parameter bit          ACTIVE_LOW = 1'b0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk_div,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] R_time_in,
    input  logic [CNT_W-1:0] G_time_in,
    input  logic [CNT_W-1:0] B_time_in,
    input  logic [CNT_W-1:0] bright,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             R_pwm,
    output logic             G_pwm,
    output logic             B_pwm,
    output logic             period_end
);

    localparam int unsigned      PROD_W  = 2 * CNT_W + 1;
    localparam int unsigned      SCALE_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } pend_state_e;

    pend_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pend_r_q, pend_r_d, pend_g_q, pend_g_d, pend_b_q, pend_b_d;
    logic [CNT_W-1:0] act_r_q, act_r_d, act_g_q, act_g_d, act_b_q, act_b_d;
    logic             r_pwm_q, r_pwm_d, g_pwm_q, g_pwm_d, b_pwm_q, b_pwm_d;
    logic             period_end_q, period_end_d;
    logic             boundary;
    logic [SCALE_W-1:0] scale;

    // bright+1 keeps full brightness an exact identity after the >> CNT_W
    function automatic logic [CNT_W-1:0] scale_duty(input logic [CNT_W-1:0]   duty,
                                                    input logic [SCALE_W-1:0] s);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(duty) * PROD_W'(s);
        return CNT_W'(prod >> CNT_W);
    endfunction

    assign duty_ready = (state_q == EMPTY);
    assign R_pwm      = r_pwm_q;
    assign G_pwm      = g_pwm_q;
    assign B_pwm      = b_pwm_q;
    assign period_end = period_end_q;

    // Next-state: counter, pending-buffer FSM, boundary transfer and PWM compare
    always_comb begin
        state_d  = state_q;
        pend_r_d = pend_r_q;
        pend_g_d = pend_g_q;
        pend_b_d = pend_b_q;
        act_r_d  = act_r_q;
        act_g_d  = act_g_q;
        act_b_d  = act_b_q;

        boundary = en && (cnt_q == CNT_MAX);
        scale    = SCALE_W'(bright) + SCALE_W'(1);
        cnt_d    = en ? cnt_q + CNT_W'(1) : '0;

        case (state_q)
            EMPTY: begin
                if (duty_valid) begin
                    pend_r_d = R_time_in;
                    pend_g_d = G_time_in;
                    pend_b_d = B_time_in;
                    state_d  = FULL;
                end
            end
            FULL: begin
                if (boundary) begin
                    act_r_d = scale_duty(pend_r_q, scale);
                    act_g_d = scale_duty(pend_g_q, scale);
                    act_b_d = scale_duty(pend_b_q, scale);
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        r_pwm_d      = en ? ((cnt_q < act_r_q) ^ ACTIVE_LOW) : ACTIVE_LOW;
        g_pwm_d      = en ? ((cnt_q < act_g_q) ^ ACTIVE_LOW) : ACTIVE_LOW;
        b_pwm_d      = en ? ((cnt_q < act_b_q) ^ ACTIVE_LOW) : ACTIVE_LOW;
        period_end_d = boundary;
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            cnt_q        <= '0;
            pend_r_q     <= '0;
            pend_g_q     <= '0;
            pend_b_q     <= '0;
            act_r_q      <= '0;
            act_g_q      <= '0;
            act_b_q      <= '0;
            r_pwm_q      <= ACTIVE_LOW;
            g_pwm_q      <= ACTIVE_LOW;
            b_pwm_q      <= ACTIVE_LOW;
            period_end_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_r_q     <= pend_r_d;
            pend_g_q     <= pend_g_d;
            pend_b_q     <= pend_b_d;
            act_r_q      <= act_r_d;
            act_g_q      <= act_g_d;
            act_b_q      <= act_b_d;
            r_pwm_q      <= r_pwm_d;
            g_pwm_q      <= g_pwm_d;
            b_pwm_q      <= b_pwm_d;
            period_end_q <= period_end_d;
        end
    end

endmodule

// File: tb/tb_rgb_pwm_encoder.sv
// Self-checking bench for rgb_pwm_encoder: an active-high and an active-low instance share all stimulus.
// A per-period waveform check compares every sample against the hand-computed duty.
module tb_rgb_pwm_encoder;

    localparam int unsigned CNT_W  = 8;
    localparam int          PERIOD = 256;

    logic             clk_div = 1'b0;
    logic             rst;
    logic             en;
    logic             duty_valid;
    logic [CNT_W-1:0] r_in, g_in, b_in, bright;
    logic             rdy0, r0, g0, b0, pe0;
    logic             rdy1, r1, g1, b1, pe1;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] rdy_first;
    bit         found;
    int         bad;

    typedef struct {
        logic [7:0] r, g, b, br;
        int         er, eg, eb;
    } vec_t;
    vec_t tbl[6];

    always #5 clk_div = ~clk_div;

    rgb_pwm_encoder #(.ACTIVE_LOW(1'b0), .CNT_W(CNT_W)) u_dut0 (
        .clk_div(clk_div), .rst(rst), .en(en),
        .R_time_in(r_in), .G_time_in(g_in), .B_time_in(b_in), .bright(bright),
        .duty_valid(duty_valid), .duty_ready(rdy0),
        .R_pwm(r0), .G_pwm(g0), .B_pwm(b0), .period_end(pe0)
    );

    rgb_pwm_encoder #(.ACTIVE_LOW(1'b1), .CNT_W(CNT_W)) u_dut1 (
        .clk_div(clk_div), .rst(rst), .en(en),
        .R_time_in(r_in), .G_time_in(g_in), .B_time_in(b_in), .bright(bright),
        .duty_valid(duty_valid), .duty_ready(rdy1),
        .R_pwm(r1), .G_pwm(g1), .B_pwm(b1), .period_end(pe1)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_div);
    endtask

    // Advance to the cycle in which period_end is high (cnt==0 in that cycle)
    task automatic wait_pe(input string tag);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 600 && !hit; n++) begin
            @(negedge clk_div);
            if (pe0 === 1'b1) hit = 1'b1;
        end
        chk($sformatf("%s_pe_seen", tag), int'(hit && (pe1 === 1'b1)), 1);
    endtask

    // Offer a triple on an EMPTY buffer and confirm the handshake
    task automatic load(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic [7:0] br, input string tag);
        r_in = r; g_in = g; b_in = b; bright = br;
        duty_valid = 1'b1;
        chk($sformatf("%s_ready", tag), int'({rdy1, rdy0}), 3);
        tick(1);
        chk($sformatf("%s_taken", tag), int'({rdy1, rdy0}), 0);
        duty_valid = 1'b0;
    endtask

    // Called from a period_end cycle: sample one whole period, sample k is the cnt==k compare
    task automatic measure(input int er, input int eg, input int eb, input string tag);
        int         ex[3];
        int         hi[3];
        int         shape_bad;
        int         pe_bad;
        logic [5:0] s;
        logic       e;
        ex[0] = er; ex[1] = eg; ex[2] = eb;
        hi[0] = 0; hi[1] = 0; hi[2] = 0;
        shape_bad = 0;
        pe_bad    = 0;
        for (int k = 0; k < PERIOD; k++) begin
            @(negedge clk_div);
            s = {b1, g1, r1, b0, g0, r0};
            if (k == 0) rdy_first = {rdy1, rdy0};
            for (int c = 0; c < 3; c++) begin
                e = (k < ex[c]);
                if (s[c] !== e) shape_bad++;
                if (s[c+3] !== ~e) shape_bad++;
                if (s[c] === 1'b1) hi[c]++;
            end
            if (pe0 !== (k == PERIOD - 1) || pe1 !== (k == PERIOD - 1)) pe_bad++;
        end
        chk($sformatf("%s_R_high", tag), hi[0], er);
        chk($sformatf("%s_G_high", tag), hi[1], eg);
        chk($sformatf("%s_B_high", tag), hi[2], eb);
        chk($sformatf("%s_wave", tag), shape_bad, 0);
        chk($sformatf("%s_period_end", tag), pe_bad, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{r: 8'd200, g: 8'd255, b: 8'd1,   br: 8'd127, er: 100, eg: 127, eb: 0};
        tbl[1] = '{r: 8'd255, g: 8'd128, b: 8'd17,  br: 8'd0,   er: 0,   eg: 0,   eb: 0};
        tbl[2] = '{r: 8'd255, g: 8'd100, b: 8'd3,   br: 8'd255, er: 255, eg: 100, eb: 3};
        tbl[3] = '{r: 8'd64,  g: 8'd192, b: 8'd250, br: 8'd63,  er: 16,  eg: 48,  eb: 62};
        tbl[4] = '{r: 8'd99,  g: 8'd37,  b: 8'd180, br: 8'd200, er: 77,  eg: 29,  eb: 141};
        tbl[5] = '{r: 8'd1,   g: 8'd254, b: 8'd128, br: 8'd254, er: 0,   eg: 253, eb: 127};

        // Reset held with en and duty_valid active
        rst = 1'b1; en = 1'b1; duty_valid = 1'b1;
        r_in = 8'd77; g_in = 8'd77; b_in = 8'd77; bright = 8'd255;
        tick(3);
        chk("rst_pwm_hi",     int'({r0, g0, b0}), 0);
        chk("rst_pwm_lo",     int'({r1, g1, b1}), 7);
        chk("rst_period_end", int'({pe1, pe0}), 0);
        chk("rst_ready",      int'({rdy1, rdy0}), 3);
        en = 1'b0; duty_valid = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(2);
        chk("post_rst_ready", int'({rdy1, rdy0}), 3);
        chk("post_rst_pwm",   int'({r1, g1, b1, r0, g0, b0}), 6'b111_000);

        // Basic duty, two consecutive periods
        load(8'd64, 8'd128, 8'd0, 8'd255, "basic");
        en = 1'b1;
        wait_pe("basic");
        measure(64, 128, 0, "basic_p1");
        measure(64, 128, 0, "basic_p2");

        // Double buffer: A taken mid-period, B held until the boundary frees the buffer
        tick(50);
        r_in = 8'd10; g_in = 8'd0; b_in = 8'd0; duty_valid = 1'b1;
        chk("dbuf_A_ready", int'({rdy1, rdy0}), 3);
        tick(1);
        chk("dbuf_A_taken", int'({rdy1, rdy0}), 0);
        r_in = 8'd200; g_in = 8'd20; b_in = 8'd5;
        found = 1'b0; bad = 0;
        for (int n = 0; n < 600 && !found; n++) begin
            tick(1);
            if (pe0 === 1'b1) found = 1'b1;
            else if ({rdy1, rdy0} !== 2'b00) bad++;
        end
        chk("dbuf_pe_seen", int'(found), 1);
        chk("dbuf_full_not_ready", bad, 0);
        chk("dbuf_ready_at_boundary", int'({rdy1, rdy0}), 3);
        measure(10, 0, 0, "dbuf_A");
        chk("dbuf_B_taken", int'(rdy_first), 0);
        duty_valid = 1'b0;
        measure(200, 20, 5, "dbuf_B");

        // Brightness scaling vectors
        for (int i = 0; i < 6; i++) begin
            load(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].br, $sformatf("vec%0d", i));
            wait_pe($sformatf("vec%0d", i));
            measure(tbl[i].er, tbl[i].eg, tbl[i].eb, $sformatf("vec%0d", i));
        end

        // Enable dropped at cnt=100 with act_R=150, triple offered while disabled
        load(8'd150, 8'd0, 8'd0, 8'd255, "en");
        wait_pe("en");
        tick(100);
        chk("en_before_drop", int'({r1, r0}), 1);
        en = 1'b0;
        tick(1);
        chk("en_drop_pwm", int'({r1, r0}), 2);
        load(8'd30, 8'd0, 8'd0, 8'd255, "en_off");
        bad = 0;
        for (int n = 0; n < 298; n++) begin
            tick(1);
            if ({pe1, pe0} !== 2'b00 || {r0, g0, b0} !== 3'b000 || {r1, g1, b1} !== 3'b111) bad++;
        end
        chk("en_off_quiet", bad, 0);
        en = 1'b1;
        measure(150, 0, 0, "reen");
        measure(30, 0, 0, "reen_pend");

        // Asynchronous reset mid-period while FULL discards the pending triple
        tick(5);
        r_in = 8'd80; g_in = 8'd80; b_in = 8'd80; duty_valid = 1'b1;
        tick(1);
        duty_valid = 1'b0;
        tick(5);
        chk("pre_rst_active", int'({r1, r0}), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pwm",   int'({r1, g1, b1, r0, g0, b0}), 6'b111_000);
        chk("async_rst_pe",    int'({pe1, pe0}), 0);
        chk("async_rst_ready", int'({rdy1, rdy0}), 3);
        @(negedge clk_div);
        rst = 1'b0;
        wait_pe("rst");
        measure(0, 0, 0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
